// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial adder scheduler.
//   - FSM state encodings (IDLE, LOAD, SHIFT, DONE) and the state_t enum
//   - ID_W: width of a requester identifier
package serial_add_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_LOAD  = LOAD,
        ST_SHIFT = SHIFT,
        ST_DONE  = DONE
    } state_t;

endpackage

// File: rtl/serial_add_bit.sv
// serial_add_bit: one-bit full adder with a carry flip-flop.
// The sum bit is combinational from the current operand bits and the stored
// carry; the carry register advances only when en is high.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears carry)
//   clr   : synchronous carry clear, has priority over en
//   en    : advance the carry by one bit position
//   a, b  : operand bits for the current position
//   s     : sum bit for the current position
module serial_add_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s
);

    logic carry;

    assign s = a ^ b ^ carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= (a & b) | (a & carry) | (b & carry);
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched: shares one bit-serial adder between two requesters.
// A round-robin arbiter picks a requester in IDLE, its operands are captured,
// the sum is built LSB-first over WIDTH+1 clocks, and a done pulse tagged
// with the requester ID presents the WIDTH+1-bit result.
//   clk      : clock, all state on posedge
//   rst_n    : asynchronous active-low reset
//   req[1:0] : per-requester request, held with operands until its gnt bit
//   a0, b0   : requester 0 operands
//   a1, b1   : requester 1 operands
//   gnt[1:0] : one-hot, one-cycle grant (operands captured)
//   busy     : high while in LOAD, SHIFT or DONE
//   done     : one-cycle pulse, result valid
//   done_id  : requester owning result, held until the next done
//   result   : {carry, sum bits}
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [WIDTH:0]   result
);

    // Counter must be able to hold the value WIDTH.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;

    state_t           state;
    state_t           next_state;
    logic [ID_W-1:0]  last_winner;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  pick;
    logic [WIDTH:0]   op_a;
    logic [WIDTH:0]   op_b;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             shift_en;
    logic             sum_bit;

    // Round-robin: on a tie the requester that did not win last time goes.
    always_comb begin
        pick = '0;
        if (req == 2'b11) begin
            pick = ~last_winner;
        end else if (req[1]) begin
            pick = ID_W'(1);
        end
    end

    assign capture  = (state == ST_IDLE) && (req != 2'b00);
    assign shift_en = (state == ST_SHIFT);

    serial_add_bit u_bit (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .en    (shift_en),
        .a     (op_a[0]),
        .b     (op_b[0]),
        .s     (sum_bit)
    );

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (capture) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(WIDTH)) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are registered from next_state so they change only on the
    // clock edge and line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
        end else begin
            gnt <= 2'b00;
            if (next_state == ST_LOAD) begin
                gnt <= (pick != '0) ? 2'b10 : 2'b01;
            end
            busy <= (next_state != ST_IDLE);
            done <= (next_state == ST_DONE);
            if (next_state == ST_DONE) begin
                done_id <= winner;
            end
        end
    end

    // Operand capture, shift registers, bit counter and result deserialiser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            cnt         <= '0;
            winner      <= '0;
            last_winner <= ID_W'(1);
        end else if (capture) begin
            winner      <= pick;
            last_winner <= pick;
            op_a        <= (pick != '0) ? {1'b0, a1} : {1'b0, a0};
            op_b        <= (pick != '0) ? {1'b0, b1} : {1'b0, b0};
            result      <= '0;
        end else if (state == ST_LOAD) begin
            cnt <= '0;
        end else if (shift_en) begin
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            result <= {sum_bit, result[WIDTH:1]};
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: table-driven single-requester vectors,
// hand-written multi-cycle sequences and a randomized run checked against
// a round-robin / a+b reference model.
module tb_serial_add_sched;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [WIDTH-1:0] a0 = '0;
    logic [WIDTH-1:0] b0 = '0;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] b1 = '0;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic [0:0]       done_id;
    logic [WIDTH:0]   result;

    int n_tests  = 0;
    int n_fail   = 0;
    int mon_fail = 0;
    int last     = 1;

    always #5 clk = ~clk;

    serial_add_sched #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result)
    );

    typedef struct {
        logic [1:0]       req;
        logic [WIDTH-1:0] a0, b0, a1, b1;
        logic [1:0]       gnt;
        int               res;
        int               id;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Protocol monitor: grant shape and done pulse shape on every cycle.
    logic [1:0] gnt_q  = 2'b00;
    logic       done_q = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            gnt_q  <= 2'b00;
            done_q <= 1'b0;
        end else begin
            gnt_q  <= gnt;
            done_q <= done;
            if (gnt == 2'b11) begin
                mon_fail <= mon_fail + 1;
                $display("FAIL mon_onehot: gnt=%b, expected one-hot or zero", gnt);
            end
            if (gnt != 2'b00 && (!busy || done || gnt_q != 2'b00)) begin
                mon_fail <= mon_fail + 1;
                $display("FAIL mon_gnt_load: gnt=%b busy=%b done=%b prev_gnt=%b", gnt, busy, done, gnt_q);
            end
            if (done && (done_q || !busy)) begin
                mon_fail <= mon_fail + 1;
                $display("FAIL mon_done_pulse: done=%b prev_done=%b busy=%b", done, done_q, busy);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt(output logic [1:0] g, output int cyc);
        g   = 2'b00;
        cyc = 0;
        while (g == 2'b00 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            g = gnt;
        end
        if (g == 2'b00) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_timeout: no gnt within %0d cycles", cyc);
        end
    endtask

    task automatic wait_done(output int cyc, output logic [1:0] gseen);
        logic d;
        d     = 1'b0;
        cyc   = 0;
        gseen = 2'b00;
        while (!d && cyc < 30) begin
            @(negedge clk);
            cyc++;
            d     = done;
            gseen = gseen | gnt;
        end
        if (!d) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last  = 1;
    endtask

    // One request that is alone on the bus; expectations come from the caller.
    task automatic single(input string nm, input vec_t v);
        logic [1:0] g;
        logic [1:0] gs;
        int         c;
        int         d;
        a0  = v.a0;
        b0  = v.b0;
        a1  = v.a1;
        b1  = v.b1;
        req = v.req;
        wait_gnt(g, c);
        req = 2'b00;
        chk({nm, "_gnt"}, int'(g), int'(v.gnt));
        chk({nm, "_gnt_lat"}, c, 1);
        chk({nm, "_res_clr"}, int'(result), 0);
        last = (v.gnt == 2'b10) ? 1 : 0;
        wait_done(d, gs);
        chk({nm, "_done_lat"}, d, WIDTH + 2);
        chk({nm, "_res"}, int'(result), v.res);
        chk({nm, "_id"}, int'(done_id), v.id);
        chk({nm, "_no_gnt"}, int'(gs), 0);
        @(negedge clk);
        chk({nm, "_done_low"}, int'(done), 0);
        chk({nm, "_idle"}, int'(busy), 0);
    endtask

    logic [1:0] g, gs, r;
    int         c, d, w, ea, eb;
    vec_t       v;

    initial begin
        tbl[0] = '{req: 2'b01, a0: 3'd5, b0: 3'd6, a1: 3'd0, b1: 3'd0, gnt: 2'b01, res: 11, id: 0};
        tbl[1] = '{req: 2'b10, a0: 3'd0, b0: 3'd0, a1: 3'd7, b1: 3'd7, gnt: 2'b10, res: 14, id: 1};
        tbl[2] = '{req: 2'b01, a0: 3'd0, b0: 3'd0, a1: 3'd7, b1: 3'd7, gnt: 2'b01, res: 0,  id: 0};
        tbl[3] = '{req: 2'b10, a0: 3'd1, b0: 3'd1, a1: 3'd7, b1: 3'd0, gnt: 2'b10, res: 7,  id: 1};
        tbl[4] = '{req: 2'b01, a0: 3'd7, b0: 3'd7, a1: 3'd0, b1: 3'd0, gnt: 2'b01, res: 14, id: 0};
        tbl[5] = '{req: 2'b10, a0: 3'd0, b0: 3'd0, a1: 3'd4, b1: 3'd3, gnt: 2'b10, res: 7,  id: 1};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_result", int'(result), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
            single($sformatf("vec%0d", i), tbl[i]);
        end

        // Both requesting after reset: 0 wins first, then 1, captures 7 apart.
        do_reset();
        a0 = 3'd1; b0 = 3'd2; a1 = 3'd3; b1 = 3'd3;
        req = 2'b11;
        wait_gnt(g, c);
        chk("rr_first_gnt", int'(g), 1);
        req = 2'b10;
        wait_done(d, gs);
        chk("rr_first_res", int'(result), 3);
        chk("rr_first_id", int'(done_id), 0);
        wait_gnt(g, c);
        req = 2'b00;
        chk("rr_second_gnt", int'(g), 2);
        chk("rr_spacing", d + c, WIDTH + 4);
        wait_done(d, gs);
        chk("rr_second_res", int'(result), 6);
        chk("rr_second_id", int'(done_id), 1);
        @(negedge clk);
        last = 1;

        // Request raised mid-SHIFT is held off until IDLE.
        a1 = 3'd2; b1 = 3'd5;
        req = 2'b10;
        wait_gnt(g, c);
        req = 2'b00;
        chk("busy_first_gnt", int'(g), 2);
        repeat (2) @(negedge clk);
        a0 = 3'd1; b0 = 3'd1;
        req = 2'b01;
        wait_done(d, gs);
        chk("busy_no_gnt", int'(gs), 0);
        chk("busy_res", int'(result), 7);
        chk("busy_id", int'(done_id), 1);
        wait_gnt(g, c);
        req = 2'b00;
        chk("busy_late_gnt", int'(g), 1);
        chk("busy_late_lat", c, 2);
        wait_done(d, gs);
        chk("busy_late_res", int'(result), 2);
        chk("busy_late_id", int'(done_id), 0);
        @(negedge clk);
        last = 0;

        // Reset two cycles into SHIFT aborts the operation.
        a0 = 3'd5; b0 = 3'd5;
        req = 2'b01;
        wait_gnt(g, c);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", int'(gnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_id", int'(done_id), 0);
        chk("abort_result", int'(result), 0);
        repeat (2) @(negedge clk);
        chk("abort_done_held", int'(done), 0);
        rst_n = 1'b1;
        last  = 1;
        @(negedge clk);
        chk("abort_after_done", int'(done), 0);
        v = '{req: 2'b01, a0: 3'd3, b0: 3'd4, a1: 3'd0, b1: 3'd0, gnt: 2'b01, res: 7, id: 0};
        single("fresh", v);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1000; i++) begin
            r  = 2'($urandom_range(1, 3));
            a0 = 3'($urandom);
            b0 = 3'($urandom);
            a1 = 3'($urandom);
            b1 = 3'($urandom);
            if (r == 2'b11) w = (last == 0) ? 1 : 0;
            else            w = r[1] ? 1 : 0;
            ea  = (w == 1) ? int'(a1) : int'(a0);
            eb  = (w == 1) ? int'(b1) : int'(b0);
            req = r;
            wait_gnt(g, c);
            req = 2'b00;
            chk("rnd_gnt", int'(g), (w == 1) ? 2 : 1);
            last = w;
            wait_done(d, gs);
            chk("rnd_lat", d, WIDTH + 2);
            chk("rnd_res", int'(result), ea + eb);
            chk("rnd_id", int'(done_id), w);
            @(negedge clk);
        end

        chk("monitor_violations", mon_fail, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
